// File: rtl/nand_op_sequencer.sv
// Sequential 2-input boolean unit: any of eight functions is evaluated by stepping one
// shared W-bit NAND array through a short micro-sequence, arbitrated between two requesters.
module nand_op_sequencer #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [W-1:0]     req0_a_i,
  input  logic [W-1:0]     req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [W-1:0]     req1_a_i,
  input  logic [W-1:0]     req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [W-1:0]     rsp_data_o,
  output logic             rsp_id_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] ops_done_o
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_T2} src_e;
  typedef enum logic [1:0] {DST_T0, DST_T1, DST_T2, DST_OUT} dst_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d, step_q, step_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             id_q, id_d, rr_q, rr_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic             gnt_any, gnt_id;
  src_e             x_sel, y_sel;
  dst_e             dst;
  logic [W-1:0]     x_bus, y_bus, nand_y;

  // rr_q names the requester that wins when both are valid.
  always_comb begin
    gnt_any = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) gnt_id = rr_q;
    else                              gnt_id = req1_valid_i;
  end

  // Micro-sequence table: NAND operand sources and destination for (op, step).
  always_comb begin
    x_sel = SRC_A;
    y_sel = SRC_B;
    dst   = DST_OUT;
    case (op_q)
      3'd1: if (step_q == 3'd0) dst = DST_T0;
            else begin x_sel = SRC_T0; y_sel = SRC_T0; end
      3'd2, 3'd3: case (step_q)
        3'd0:    begin x_sel = SRC_A;  y_sel = SRC_A;  dst = DST_T0; end
        3'd1:    begin x_sel = SRC_B;  y_sel = SRC_B;  dst = DST_T1; end
        3'd2:    begin x_sel = SRC_T0; y_sel = SRC_T1; dst = (op_q == 3'd3) ? DST_T2 : DST_OUT; end
        default: begin x_sel = SRC_T2; y_sel = SRC_T2; end
      endcase
      3'd4, 3'd5: case (step_q)
        3'd0:    dst = DST_T0;
        3'd1:    begin x_sel = SRC_A;  y_sel = SRC_T0; dst = DST_T1; end
        3'd2:    begin x_sel = SRC_B;  y_sel = SRC_T0; dst = DST_T2; end
        3'd3:    begin x_sel = SRC_T1; y_sel = SRC_T2; dst = (op_q == 3'd5) ? DST_T0 : DST_OUT; end
        default: begin x_sel = SRC_T0; y_sel = SRC_T0; end
      endcase
      3'd6:    y_sel = SRC_A;
      3'd7:    x_sel = SRC_B;
      default: ;
    endcase
  end

  always_comb begin
    case (x_sel)
      SRC_A:   x_bus = a_q;
      SRC_B:   x_bus = b_q;
      SRC_T0:  x_bus = t0_q;
      SRC_T1:  x_bus = t1_q;
      default: x_bus = t2_q;
    endcase
    case (y_sel)
      SRC_A:   y_bus = a_q;
      SRC_B:   y_bus = b_q;
      SRC_T0:  y_bus = t0_q;
      SRC_T1:  y_bus = t1_q;
      default: y_bus = t2_q;
    endcase
  end

  for (genvar gi = 0; gi < W; gi++) begin : g_nand
    assign nand_y[gi] = ~(x_bus[gi] & y_bus[gi]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= '0;
      step_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      t0_q       <= '0;
      t1_q       <= '0;
      t2_q       <= '0;
      rsp_data_q <= '0;
      id_q       <= 1'b0;
      rr_q       <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      step_q     <= step_d;
      a_q        <= a_d;
      b_q        <= b_d;
      t0_q       <= t0_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      rsp_data_q <= rsp_data_d;
      id_q       <= id_d;
      rr_q       <= rr_d;
      ops_done_q <= ops_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    step_d     = step_q;
    a_d        = a_q;
    b_d        = b_q;
    t0_d       = t0_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    rsp_data_d = rsp_data_q;
    id_d       = id_q;
    rr_d       = rr_q;
    ops_done_d = ops_done_q;
    case (state_q)
      IDLE: if (gnt_any) begin
        id_d    = gnt_id;
        rr_d    = ~gnt_id;
        op_d    = gnt_id ? req1_op_i : req0_op_i;
        a_d     = gnt_id ? req1_a_i  : req0_a_i;
        b_d     = gnt_id ? req1_b_i  : req0_b_i;
        step_d  = '0;
        state_d = EXEC;
      end
      EXEC: begin
        step_d = step_q + 3'd1;
        case (dst)
          DST_T0:  t0_d = nand_y;
          DST_T1:  t1_d = nand_y;
          DST_T2:  t2_d = nand_y;
          DST_OUT: begin rsp_data_d = nand_y; state_d = RESP; end
        endcase
      end
      RESP: if (rsp_ready_i) begin
        ops_done_d = ops_done_q + CNT_W'(1);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = (state_q == IDLE) && gnt_any && !gnt_id;
    req1_ready_o = (state_q == IDLE) && gnt_any && gnt_id;
    rsp_valid_o  = (state_q == RESP);
    busy_o       = (state_q != IDLE);
  end

  assign rsp_data_o = rsp_data_q;
  assign rsp_id_o   = id_q;
  assign ops_done_o = ops_done_q;
endmodule
